lmdpl_gate_array: RTL and testbench

- N-lane LMDPL gate stage that evaluates one selectable bitwise operation over N masked dual-rail lanes per transaction.
- Contains its own precharge/evaluate sequencer, with configurable precharge length and valid/ready handshakes on both sides.
- Replaces hand-instantiated single-bit nonlinear gadgets plus a separate clock controller in wide LMDPL datapaths such as S-box layers and key-mixing.

---
 rtl/lmdpl_gate_array.sv | 141 ++++++++++++++
 tb/tb_lmdpl_gate_array.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lmdpl_gate_array.sv
// N-lane LMDPL gate stage: one bitwise op over masked dual-rail lanes per transaction,
// with its own precharge/evaluate sequencer and valid/ready handshakes on both sides.
module lmdpl_gate_array #(
   parameter int unsigned WIDTH      = 8,
   parameter logic [2:0]  OP         = 3'b000,
   parameter int unsigned PRE_CYCLES = 1
) (
   input  logic               clk,
   input  logic               Po_rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3*WIDTH-1:0] a,
   input  logic [3*WIDTH-1:0] b,
   input  logic [WIDTH-1:0]   r,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [3*WIDTH-1:0] c,
   output logic               pre
);

   typedef enum logic [2:0] {StIdle, StPre, StEval, StValid, StDrain} state_e;

   localparam logic [3:0] PreLast  = 4'(PRE_CYCLES - 1);
   localparam logic       IsLinear = OP[2];
   localparam logic       SwapIn   = OP[1] & ~OP[2];
   localparam logic       SwapOut  = OP[0];

   state_e             state_q;
   logic [3:0]         cnt_q;
   logic [3*WIDTH-1:0] opa_q, opb_q, c_q;
   logic [WIDTH-1:0]   r_q;
   logic [8*WIDTH-1:0] t_q;

   logic [3*WIDTH-1:0] opa_in, opb_in, opa_clr, opb_clr, c_eval;
   logic [8*WIDTH-1:0] t_in;
   logic [2:0]         gate;

   function automatic logic [2:0] swap_rails(input logic [2:0] x);
      return {x[1], x[2], x[0]};
   endfunction

   // t[{xa,xb}] is the masked and-result for masked inputs xa/xb; t[7:4] feeds the 0-rail.
   function automatic logic [7:0] table_lane(input logic ma, input logic mb, input logic rr);
      logic [3:0] t4;
      t4 = {~ma & ~mb, ~ma & mb, ma & ~mb, ma & mb} ^ {4{rr}};
      return {~t4, t4};
   endfunction

   function automatic logic [2:0] eval_lane(input logic [2:0] la, input logic [2:0] lb,
                                            input logic [7:0] tt, input logic rr);
      logic o1, o2, m;
      if (IsLinear) begin
         o1 = (la[2] & lb[1]) | (la[1] & lb[2]);
         o2 = (la[2] & lb[2]) | (la[1] & lb[1]);
         m  = la[0] ^ lb[0];
      end else begin
         o1 = (la[1] & lb[1] & tt[3]) | (la[1] & lb[2] & tt[2]) |
              (la[2] & lb[1] & tt[1]) | (la[2] & lb[2] & tt[0]);
         o2 = (la[1] & lb[1] & tt[7]) | (la[1] & lb[2] & tt[6]) |
              (la[2] & lb[1] & tt[5]) | (la[2] & lb[2] & tt[4]);
         m  = rr;
      end
      return SwapOut ? {o1, o2, m} : {o2, o1, m};
   endfunction

   // Operand rails reach the network only in EVAL; masks are never gated.
   assign gate = {(state_q == StEval), (state_q == StEval), 1'b1};

   always_comb begin
      opa_in  = '0;
      opb_in  = '0;
      opa_clr = '0;
      opb_clr = '0;
      c_eval  = '0;
      t_in    = '0;
      for (int k = 0; k < WIDTH; k++) begin
         opa_in[3*k +: 3]  = SwapIn ? swap_rails(a[3*k +: 3]) : a[3*k +: 3];
         opb_in[3*k +: 3]  = SwapIn ? swap_rails(b[3*k +: 3]) : b[3*k +: 3];
         t_in[8*k +: 8]    = table_lane(a[3*k], b[3*k], r[k]);
         opa_clr[3*k +: 3] = {2'b00, opa_q[3*k]};
         opb_clr[3*k +: 3] = {2'b00, opb_q[3*k]};
         c_eval[3*k +: 3]  = eval_lane(opa_q[3*k +: 3] & gate, opb_q[3*k +: 3] & gate,
                                       t_q[8*k +: 8], r_q[k]);
      end
   end

   always_ff @(posedge clk) begin
      if (Po_rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         r_q     <= '0;
         t_q     <= '0;
         c_q     <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  opa_q   <= opa_in;
                  opb_q   <= opb_in;
                  r_q     <= r;
                  t_q     <= t_in;
                  cnt_q   <= PreLast;
                  state_q <= StPre;
               end
            end
            StPre: begin
               if (cnt_q == 4'd0) state_q <= StEval;
               else               cnt_q   <= cnt_q - 4'd1;
            end
            StEval: begin
               c_q     <= c_eval;
               state_q <= StValid;
            end
            StValid: begin
               if (out_ready) begin
                  c_q     <= '0;
                  opa_q   <= opa_clr;
                  opb_q   <= opb_clr;
                  t_q     <= '0;
                  cnt_q   <= PreLast;
                  state_q <= StDrain;
               end
            end
            StDrain: begin
               if (cnt_q == 4'd0) state_q <= StIdle;
               else               cnt_q   <= cnt_q - 4'd1;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // c_q is non-zero only in VALID; the reset gate can only force rails low.
   assign c         = Po_rst ? '0 : c_q;
   assign in_ready  = (state_q == StIdle) & ~Po_rst;
   assign out_valid = (state_q == StValid) & ~Po_rst;
   assign pre       = (state_q != StEval) && (state_q != StValid);

endmodule

// File: tb/tb_lmdpl_gate_array.sv
// Directed bench for lmdpl_gate_array: six WIDTH=8/P=1 instances (one per op) sharing stimulus,
// plus a WIDTH=4/P=3 and-instance for backpressure and drain timing.
module tb_lmdpl_gate_array;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   logic        rst, iv, ordy;
   logic [23:0] a8, b8;
   logic [7:0]  r8;
   logic        irdy8 [6];
   logic        ov8   [6];
   logic [23:0] c8    [6];
   logic        pre8  [6];

   logic        iv3, ordy3, irdy3, ov3, pre3;
   logic [11:0] a4, b4, c3;
   logic [3:0]  r4;

   for (genvar g = 0; g < 6; g++) begin : g_op
      lmdpl_gate_array #(.WIDTH(8), .OP(3'(g)), .PRE_CYCLES(1)) u_dut (
         .clk(clk), .Po_rst(rst), .in_valid(iv), .in_ready(irdy8[g]), .a(a8), .b(b8),
         .r(r8), .out_valid(ov8[g]), .out_ready(ordy), .c(c8[g]), .pre(pre8[g]));
   end

   lmdpl_gate_array #(.WIDTH(4), .OP(3'b000), .PRE_CYCLES(3)) u_p3 (
      .clk(clk), .Po_rst(rst), .in_valid(iv3), .in_ready(irdy3), .a(a4), .b(b4), .r(r4),
      .out_valid(ov3), .out_ready(ordy3), .c(c3), .pre(pre3));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_chk++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [2:0] enc(input logic v, input logic m);
      return {~(v ^ m), v ^ m, m};
   endfunction

   function automatic logic ref_op(input int op, input logic x, input logic y);
      case (op)
         0:       return x & y;
         1:       return ~(x & y);
         2:       return ~(x | y);
         3:       return x | y;
         4:       return x ^ y;
         default: return ~(x ^ y);
      endcase
   endfunction

   logic mon_en = 1'b0;
   always @(negedge clk) begin : monitor
      logic bad;
      bad = 1'b0;
      if (mon_en) begin
         for (int g = 0; g < 6; g++) begin
            for (int k = 0; k < 8; k++) if (c8[g][3*k+1] & c8[g][3*k+2]) bad = 1'b1;
            if (!ov8[g] && c8[g] != 24'd0) bad = 1'b1;
         end
         for (int k = 0; k < 4; k++) if (c3[3*k+1] & c3[3*k+2]) bad = 1'b1;
         if (!ov3 && c3 != 12'd0) bad = 1'b1;
         chk("rail_monitor", 64'(bad), 64'd0);
      end
   end

   task automatic idle_reset_checks(input string tag);
      for (int g = 0; g < 6; g++) begin
         chk({tag, "_in_ready"}, 64'(irdy8[g]), 64'd0);
         chk({tag, "_out_valid"}, 64'(ov8[g]), 64'd0);
         chk({tag, "_c"}, 64'(c8[g]), 64'd0);
      end
   endtask

   task automatic txn(input int idx);
      logic [23:0] expc [6];
      logic        va, ma, vb, mb, rr;
      int          lat;
      for (int k = 0; k < 8; k++) begin
         va = 1'($urandom_range(1)); ma = 1'($urandom_range(1));
         vb = 1'($urandom_range(1)); mb = 1'($urandom_range(1));
         rr = 1'($urandom_range(1));
         a8[3*k +: 3] = enc(va, ma);
         b8[3*k +: 3] = enc(vb, mb);
         r8[k]        = rr;
         for (int op = 0; op < 6; op++)
            expc[op][3*k +: 3] = enc(ref_op(op, va, vb), (op >= 4) ? (ma ^ mb) : rr);
      end
      iv = 1'b1;
      step(1);
      iv = 1'b0;
      lat = 1;
      forever begin
         @(negedge clk);
         if (ov8[0] || lat >= 20) break;
         lat++;
      end
      chk($sformatf("sweep%0d_latency", idx), 64'(lat), 64'd3);
      for (int op = 0; op < 6; op++)
         chk($sformatf("sweep%0d_op%0d_c", idx, op), 64'(c8[op]), 64'(expc[op]));
      ordy = 1'b1;
      step(1);
      ordy = 1'b0;
      step(1);
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not reach the summary");
      $fatal(1);
   end

   initial begin
      logic [2:0] exp1 [6];
      logic [2:0] e;
      int         lat;
      int         cyc;
      int         acc [$];

      exp1 = '{3'b101, 3'b011, 3'b011, 3'b101, 3'b011, 3'b101};
      rst = 1'b1; iv = 1'b0; ordy = 1'b0; iv3 = 1'b0; ordy3 = 1'b0;
      a8 = '0; b8 = '0; r8 = '0; a4 = '0; b4 = '0; r4 = '0;

      // Reset state
      step(2);
      @(negedge clk);
      idle_reset_checks("reset");
      step(1);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_in_ready", 64'(irdy8[0]), 64'd1);
      chk("idle_pre", 64'(pre8[0]), 64'd1);
      chk("idle_out_valid", 64'(ov8[0]), 64'd0);
      mon_en = 1'b1;

      // Directed: a=101 (v=1,m=1), b=010 (v=1,m=0), r=1, every op
      a8 = {8{3'b101}}; b8 = {8{3'b010}}; r8 = 8'hFF;
      step(1);
      iv = 1'b1;
      step(1);
      iv = 1'b0;
      @(negedge clk);
      chk("dir_pre_in_pre", 64'(pre8[0]), 64'd1);
      chk("dir_in_ready_busy", 64'(irdy8[0]), 64'd0);
      step(1);
      @(negedge clk);
      chk("dir_pre_in_eval", 64'(pre8[0]), 64'd0);
      chk("dir_no_valid_in_eval", 64'(ov8[0]), 64'd0);
      step(1);
      @(negedge clk);
      for (int g = 0; g < 6; g++) begin
         e = exp1[g];
         chk($sformatf("dir_op%0d_valid", g), 64'(ov8[g]), 64'd1);
         chk($sformatf("dir_op%0d_c", g), 64'(c8[g]), 64'({8{e}}));
      end
      chk("dir_pre_in_valid", 64'(pre8[0]), 64'd0);
      ordy = 1'b1;
      step(1);
      ordy = 1'b0;
      @(negedge clk);
      chk("dir_drain_valid", 64'(ov8[0]), 64'd0);
      chk("dir_drain_c", 64'(c8[0]), 64'd0);
      chk("dir_drain_in_ready", 64'(irdy8[0]), 64'd0);
      step(1);
      @(negedge clk);
      chk("dir_back_idle", 64'(irdy8[0]), 64'd1);

      // P=3 backpressure and drain timing
      a4 = {4{3'b101}}; b4 = {4{3'b010}}; r4 = 4'hF;
      step(1);
      iv3 = 1'b1;
      step(1);
      iv3 = 1'b0;
      lat = 1;
      forever begin
         @(negedge clk);
         if (ov3 || lat >= 20) break;
         lat++;
      end
      chk("p3_latency", 64'(lat), 64'd5);
      for (int i = 0; i < 10; i++) begin
         chk("p3_hold_valid", 64'(ov3), 64'd1);
         chk("p3_hold_c", 64'(c3), 64'hB6D);
         chk("p3_hold_in_ready", 64'(irdy3), 64'd0);
         @(negedge clk);
      end
      ordy3 = 1'b1;
      step(1);
      ordy3 = 1'b0;
      @(negedge clk);
      chk("p3_consume_c", 64'(c3), 64'd0);
      chk("p3_consume_valid", 64'(ov3), 64'd0);
      chk("p3_consume_in_ready", 64'(irdy3), 64'd0);
      step(1);
      @(negedge clk);
      chk("p3_drain1_in_ready", 64'(irdy3), 64'd0);
      step(1);
      @(negedge clk);
      chk("p3_drain2_in_ready", 64'(irdy3), 64'd0);
      step(1);
      @(negedge clk);
      chk("p3_drain3_in_ready", 64'(irdy3), 64'd1);

      // Back-to-back, P=1: one accept every 5 cycles
      iv = 1'b1;
      ordy = 1'b1;
      cyc = 0;
      for (int i = 0; i < 26; i++) begin
         @(negedge clk);
         cyc++;
         if (irdy8[0]) acc.push_back(cyc);
         if (ov8[0])
            for (int g = 0; g < 6; g++) begin
               e = exp1[g];
               chk($sformatf("b2b_op%0d_c", g), 64'(c8[g]), 64'({8{e}}));
            end
      end
      iv = 1'b0;
      chk("b2b_accepts", 64'(acc.size() >= 5), 64'd1);
      for (int i = 1; i < acc.size(); i++)
         chk("b2b_interval", 64'(acc[i] - acc[i-1]), 64'd5);
      step(8);
      ordy = 1'b0;

      // Reset during PRE, with in_valid held through reset
      iv = 1'b1;
      step(1);
      rst = 1'b1;
      @(negedge clk);
      idle_reset_checks("rst_pre");
      step(1);
      @(negedge clk);
      idle_reset_checks("rst_pre_next");
      step(1);
      rst = 1'b0;
      iv = 1'b0;
      @(negedge clk);
      chk("rst_pre_release_in_ready", 64'(irdy8[0]), 64'd1);
      chk("rst_pre_release_pre", 64'(pre8[0]), 64'd1);
      step(2);
      @(negedge clk);
      chk("rst_pre_no_capture", 64'(ov8[0]), 64'd0);
      chk("rst_pre_still_idle", 64'(irdy8[0]), 64'd1);

      // Reset during VALID
      step(1);
      iv = 1'b1;
      step(1);
      iv = 1'b0;
      step(2);
      @(negedge clk);
      chk("rst_valid_reached", 64'(ov8[0]), 64'd1);
      rst = 1'b1;
      #1;
      idle_reset_checks("rst_valid");
      step(1);
      @(negedge clk);
      idle_reset_checks("rst_valid_next");
      step(1);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_valid_release_in_ready", 64'(irdy8[0]), 64'd1);

      // Random sweep over every op
      step(1);
      for (int i = 0; i < 12; i++) txn(i);

      mon_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
